// File: rtl/d7s_scan_decoder.sv
// Receive-side decoder for a multiplexed 3-digit 7-segment display.
// Synchronizes and debounces the scan lines, decodes each digit and emits whole frames over valid/ready.
module d7s_scan_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  transistor,
    input  logic [6:0]  d7sp,
    output logic [11:0] frame_data,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic        seg_err,
    output logic        sel_err,
    output logic        overrun,
    input  logic        err_clr
);

    localparam logic [7:0] STABLE_W = 8'(STABLE_CYCLES);

    // Returns {error, code}; a blank digit decodes to F without error.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        case (seg)
            7'h3F:   seg_decode = 5'h00;
            7'h06:   seg_decode = 5'h01;
            7'h5B:   seg_decode = 5'h02;
            7'h4F:   seg_decode = 5'h03;
            7'h66:   seg_decode = 5'h04;
            7'h6D:   seg_decode = 5'h05;
            7'h7D:   seg_decode = 5'h06;
            7'h07:   seg_decode = 5'h07;
            7'h7F:   seg_decode = 5'h08;
            7'h6F:   seg_decode = 5'h09;
            7'h00:   seg_decode = 5'h0F;
            default: seg_decode = 5'h1E;
        endcase
    endfunction

    logic [9:0]  r_sync_p0;
    logic [9:0]  r_sync_p1;
    logic [7:0]  r_cnt;
    logic        r_acc_p2;
    logic [11:0] r_slot;
    logic [2:0]  r_seen;
    logic [11:0] r_frame_data;
    logic        r_frame_valid;
    logic        r_seg_err;
    logic        r_sel_err;
    logic        r_overrun;

    logic [7:0]  w_cnt_nxt;
    logic [2:0]  w_sel;
    logic [6:0]  w_seg;
    logic [4:0]  w_dec;
    logic        w_onehot;
    logic        w_wr;
    logic        w_multi;
    logic [11:0] w_slot_nxt;
    logic [2:0]  w_seen_nxt;
    logic        w_complete;
    logic        w_load;
    logic        w_drop;

    always_comb begin
        // The counter tracks how long the value now entering r_sync_p1 has been unchanged.
        w_cnt_nxt = 8'd1;
        if (r_sync_p0 == r_sync_p1)
            w_cnt_nxt = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

        w_sel      = r_sync_p1[9:7];
        w_seg      = SEG_ACTIVE_LOW ? ~r_sync_p1[6:0] : r_sync_p1[6:0];
        w_dec      = seg_decode(w_seg);
        w_onehot   = (w_sel == 3'b001) || (w_sel == 3'b010) || (w_sel == 3'b100);
        w_wr       = r_acc_p2 && w_onehot;
        w_multi    = r_acc_p2 && (w_sel != 3'b000) && !w_onehot;

        w_slot_nxt = r_slot;
        for (int i = 0; i < 3; i++) begin
            if (w_wr && w_sel[i])
                w_slot_nxt[4*i +: 4] = w_dec[3:0];
        end
        w_seen_nxt = r_seen | (w_wr ? w_sel : 3'b000);
        w_complete = w_wr && (w_seen_nxt == 3'b111);
        w_load     = w_complete && (!r_frame_valid || frame_ready);
        w_drop     = w_complete && r_frame_valid && !frame_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_p0     <= '0;
            r_sync_p1     <= '0;
            r_cnt         <= '0;
            r_acc_p2      <= 1'b0;
            r_slot        <= 12'hFFF;
            r_seen        <= '0;
            r_frame_data  <= '0;
            r_frame_valid <= 1'b0;
            r_seg_err     <= 1'b0;
            r_sel_err     <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            // p0/p1: two-flop synchronizer for the asynchronous scan lines
            r_sync_p0 <= {transistor, d7sp};
            r_sync_p1 <= r_sync_p0;
            // p2: one accept strobe per stable run
            r_cnt     <= w_cnt_nxt;
            r_acc_p2  <= (w_cnt_nxt == STABLE_W) && (r_cnt != STABLE_W);
            // p3: slot write and frame hand-off
            r_slot    <= w_slot_nxt;
            r_seen    <= w_complete ? 3'b000 : w_seen_nxt;
            if (w_load) begin
                r_frame_data  <= w_slot_nxt;
                r_frame_valid <= 1'b1;
            end else if (r_frame_valid && frame_ready) begin
                r_frame_valid <= 1'b0;
            end
            r_seg_err <= (w_wr && w_dec[4]) || (r_seg_err && !err_clr);
            r_sel_err <= w_multi || (r_sel_err && !err_clr);
            r_overrun <= w_drop || (r_overrun && !err_clr);
        end
    end

    assign frame_data  = r_frame_data;
    assign frame_valid = r_frame_valid;
    assign seg_err     = r_seg_err;
    assign sel_err     = r_sel_err;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_d7s_scan_decoder.sv
// Directed bench for d7s_scan_decoder: a table of full scans plus hand-timed corner-case sequences.
module tb_d7s_scan_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  transistor;
    logic [6:0]  d7sp;
    logic [11:0] frame_data;
    logic        frame_valid;
    logic        frame_ready;
    logic        seg_err;
    logic        sel_err;
    logic        overrun;
    logic        err_clr;

    d7s_scan_decoder #(.STABLE_CYCLES(4), .SEG_ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .transistor(transistor), .d7sp(d7sp),
        .frame_data(frame_data), .frame_valid(frame_valid), .frame_ready(frame_ready),
        .seg_err(seg_err), .sel_err(sel_err), .overrun(overrun), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          n_xfer = 0;
    int          n_vld = 0;
    int          xf0;
    int          v0;
    logic [11:0] last_xfer = 12'h000;

    // Transfers and valid cycles observed mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_valid) n_vld = n_vld + 1;
            if (frame_valid && frame_ready) begin
                n_xfer = n_xfer + 1;
                last_xfer = frame_data;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drive(input logic [2:0] s, input logic [6:0] g);
        transistor = s;
        d7sp = g;
    endtask

    task automatic scan(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2, input int dwell);
        drive(3'b001, s0); step(dwell);
        drive(3'b010, s1); step(dwell);
        drive(3'b100, s2); step(dwell);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
    endtask

    typedef struct {
        logic [6:0]  s0;
        logic [6:0]  s1;
        logic [6:0]  s2;
        logic [11:0] exp_data;
        logic        exp_seg;
    } vec_t;

    vec_t vt[5];

    initial begin
        vt[0] = '{7'h06, 7'h5B, 7'h4F, 12'h321, 1'b0};
        vt[1] = '{7'h3F, 7'h6F, 7'h7F, 12'h890, 1'b0};
        vt[2] = '{7'h66, 7'h07, 7'h7D, 12'h674, 1'b0};
        vt[3] = '{7'h5B, 7'h00, 7'h4F, 12'h3F2, 1'b0};
        vt[4] = '{7'h00, 7'h6D, 7'h49, 12'hE5F, 1'b1};

        drive(3'b000, 7'h00);
        frame_ready = 1'b1;
        err_clr = 1'b0;
        rst_n = 1'b0;
        step(3);
        check("rst_valid", 32'(frame_valid), 32'd0);
        check("rst_data", 32'(frame_data), 32'h000);
        check("rst_seg_err", 32'(seg_err), 32'd0);
        check("rst_sel_err", 32'(sel_err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        step(2);

        for (int i = 0; i < 5; i++) begin
            pulse_clr();
            xf0 = n_xfer;
            v0 = n_vld;
            scan(vt[i].s0, vt[i].s1, vt[i].s2, 20);
            check($sformatf("vec%0d_xfers", i), 32'(n_xfer), 32'(xf0 + 1));
            check($sformatf("vec%0d_data", i), 32'(last_xfer), 32'(vt[i].exp_data));
            check($sformatf("vec%0d_vld_cycles", i), 32'(n_vld), 32'(v0 + 1));
            check($sformatf("vec%0d_seg_err", i), 32'(seg_err), 32'(vt[i].exp_seg));
            check($sformatf("vec%0d_sel_err", i), 32'(sel_err), 32'd0);
            check($sformatf("vec%0d_overrun", i), 32'(overrun), 32'd0);
        end
        step(10);
        check("seg_err_sticky", 32'(seg_err), 32'd1);
        pulse_clr();
        check("seg_err_cleared", 32'(seg_err), 32'd0);

        // Exact latency: last digit appears just before edge t, frame valid after edge t+5.
        drive(3'b001, 7'h06); step(20);
        drive(3'b010, 7'h5B); step(20);
        drive(3'b100, 7'h4F);
        step(5);
        check("lat_not_yet", 32'(frame_valid), 32'd0);
        step(1);
        check("lat_valid", 32'(frame_valid), 32'd1);
        check("lat_data", 32'(frame_data), 32'h321);
        step(1);
        check("lat_valid_fall", 32'(frame_valid), 32'd0);
        step(10);

        // Short glitch on digit1 must never be accepted.
        xf0 = n_xfer;
        drive(3'b001, 7'h06); step(20);
        drive(3'b010, 7'h5B); step(8);
        drive(3'b010, 7'h7F); step(2);
        drive(3'b010, 7'h5B); step(10);
        drive(3'b100, 7'h4F); step(20);
        check("glitch_xfers", 32'(n_xfer), 32'(xf0 + 1));
        check("glitch_data", 32'(last_xfer), 32'h321);
        check("glitch_seg_err", 32'(seg_err), 32'd0);

        // Illegal select stores nothing: digits 1 and 2 alone must not complete a frame.
        drive(3'b000, 7'h00); step(10);
        xf0 = n_xfer;
        drive(3'b011, 7'h06); step(20);
        check("sel_err_set", 32'(sel_err), 32'd1);
        check("sel_no_valid", 32'(frame_valid), 32'd0);
        drive(3'b010, 7'h5B); step(20);
        drive(3'b100, 7'h4F); step(20);
        check("sel_no_frame", 32'(n_xfer), 32'(xf0));
        drive(3'b001, 7'h06); step(20);
        check("sel_frame_after", 32'(n_xfer), 32'(xf0 + 1));
        check("sel_frame_data", 32'(last_xfer), 32'h321);
        pulse_clr();
        check("sel_err_cleared", 32'(sel_err), 32'd0);

        // Set beats a simultaneous clear.
        drive(3'b000, 7'h00); step(10);
        err_clr = 1'b1;
        drive(3'b110, 7'h06);
        step(5);
        check("setwin_before", 32'(sel_err), 32'd0);
        step(1);
        check("setwin_set", 32'(sel_err), 32'd1);
        step(1);
        check("setwin_cleared", 32'(sel_err), 32'd0);
        err_clr = 1'b0;

        // Overrun: second frame dropped while the first is unconsumed.
        drive(3'b000, 7'h00); step(10);
        frame_ready = 1'b0;
        xf0 = n_xfer;
        scan(7'h06, 7'h5B, 7'h4F, 20);
        check("ovr_first_valid", 32'(frame_valid), 32'd1);
        check("ovr_first_data", 32'(frame_data), 32'h321);
        check("ovr_flag_clear", 32'(overrun), 32'd0);
        scan(7'h66, 7'h6D, 7'h7D, 20);
        check("ovr_flag", 32'(overrun), 32'd1);
        check("ovr_data_kept", 32'(frame_data), 32'h321);
        check("ovr_valid_kept", 32'(frame_valid), 32'd1);
        check("ovr_no_xfer", 32'(n_xfer), 32'(xf0));
        frame_ready = 1'b1;
        step(1);
        check("ovr_valid_fall", 32'(frame_valid), 32'd0);
        check("ovr_xfer", 32'(n_xfer), 32'(xf0 + 1));
        check("ovr_xfer_data", 32'(last_xfer), 32'h321);
        pulse_clr();
        check("ovr_cleared", 32'(overrun), 32'd0);

        // Reset mid-frame discards the partial frame.
        drive(3'b000, 7'h00); step(10);
        drive(3'b001, 7'h07); step(20);
        drive(3'b010, 7'h7F); step(20);
        #1;
        rst_n = 1'b0;
        drive(3'b000, 7'h00);
        #1;
        check("arst_data", 32'(frame_data), 32'h000);
        check("arst_valid", 32'(frame_valid), 32'd0);
        step(3);
        rst_n = 1'b1;
        step(3);
        xf0 = n_xfer;
        drive(3'b100, 7'h06); step(20);
        check("arst_partial_gone", 32'(n_xfer), 32'(xf0));
        drive(3'b001, 7'h6F); step(20);
        drive(3'b010, 7'h3F); step(20);
        check("arst_one_frame", 32'(n_xfer), 32'(xf0 + 1));
        check("arst_frame_data", 32'(last_xfer), 32'h109);
        check("arst_flags", 32'({seg_err, sel_err, overrun}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
